// File: rtl/sprite_sched_pkg.sv
// Shared types, constants and command-word helpers for the sprite frame scheduler.
// Optional status/overrun logic in the top is enabled by defining SPRITE_SCHED_STATUS_EN.
package sprite_sched_pkg;

  localparam int          N_SLOTS  = 8;
  localparam int          SLOT_AW  = 3;
  localparam logic [9:0]  V_ACTIVE = 10'd480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    SWAP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] INFO_SWAP   = 4'hF;
  localparam logic [3:0] INFO_UPDATE = 4'h1;

  // Command word field positions
  localparam int COMP_MSB  = 31;
  localparam int COMP_LSB  = 26;
  localparam int CHILD_LSB = 21;
  localparam int INFO_LSB  = 17;
  localparam int TYPE_LSB  = 14;
  localparam int SEL_BIT   = 13;

  localparam logic [31:0] SEL_MASK = 32'h0000_2000;

  // Buffer-swap command for one component, targeting buffer sel.
  function automatic logic [31:0] make_swap_word(input logic [5:0] comp_id, input logic sel);
    return {comp_id, 5'd0, INFO_SWAP, 3'd0, sel, 13'd0};
  endfunction

  // Slot payload with the buffer-select bit overridden to sel.
  function automatic logic [31:0] make_update_word(input logic [31:0] slot_word, input logic sel);
    return (slot_word & ~SEL_MASK) | (sel ? SEL_MASK : 32'd0);
  endfunction

endpackage

// File: rtl/sprite_slot_table.sv
// Per-sprite slot table: N_SLOTS entries of {valid, command payload}.
// One write port, one asynchronous read port; a read returns the stored
// value even when the same entry is being written in that cycle.
module sprite_slot_table
  import sprite_sched_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [SLOT_AW-1:0] wr_addr,
  input  logic [31:0]        wr_data,
  input  logic [SLOT_AW-1:0] rd_addr,
  output logic               rd_valid,
  output logic [31:0]        rd_data
);

  logic [32:0] mem_r [N_SLOTS];

  // Storage: clear all entries on reset, a zero comp_id marks the slot invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        mem_r[i] <= 33'd0;
      end
    end else if (wr_en) begin
      mem_r[wr_addr] <= {(wr_data[COMP_MSB:COMP_LSB] != 6'd0), wr_data};
    end
  end

  assign rd_valid = mem_r[rd_addr][32];
  assign rd_data  = mem_r[rd_addr][31:0];

endmodule

// File: rtl/sprite_frame_scheduler.sv
// Sprite frame scheduler: at each vblank start flushes valid slots into the
// display back buffer, then broadcasts buffer-swap commands to the flushed
// components. Define SPRITE_SCHED_STATUS_EN for the status word
// (busy, sticky overrun, front_sel, frame counter).
module sprite_frame_scheduler
  import sprite_sched_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               host_write,
  input  logic [SLOT_AW-1:0] host_address,
  input  logic [31:0]        host_writedata,
  input  logic [9:0]         hcount,
  input  logic [9:0]         vcount,
  output logic [31:0]        disp_writedata,
  output logic               sched_busy,
  output logic               frame_done,
  output logic [31:0]        status_readdata
);

  localparam logic [SLOT_AW-1:0] LAST_IDX = SLOT_AW'(N_SLOTS - 1);

  state_t             state_r;
  logic [SLOT_AW-1:0] idx_r;
  logic [31:0]        disp_r;
  logic               busy_r;
  logic               done_r;
  logic               front_sel_r;
  logic               vb_r;
  logic               vb_d_r;
  logic [5:0]         swap_id_r [N_SLOTS];
  logic [N_SLOTS-1:0] swap_vld_r;

  logic               trigger_s;
  logic [SLOT_AW-1:0] nxt_idx_s;
  logic [SLOT_AW-1:0] rd_addr_s;
  logic               rd_valid_s;
  logic [31:0]        rd_data_s;
  logic [31:0]        upd_word_s;
  logic [31:0]        swp_word_s;
  logic               hcount_unused_s;

  assign hcount_unused_s = ^hcount;

  // Words are registered together with the state, so the table is read one
  // slot ahead of the index currently on the bus.
  assign nxt_idx_s = idx_r + 3'd1;
  assign rd_addr_s = (state_r == FLUSH) ? nxt_idx_s : {SLOT_AW{1'b0}};

  sprite_slot_table u_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (host_write),
    .wr_addr  (host_address),
    .wr_data  (host_writedata),
    .rd_addr  (rd_addr_s),
    .rd_valid (rd_valid_s),
    .rd_data  (rd_data_s)
  );

  // Next update/swap words, targeting the current back buffer.
  always_comb begin
    upd_word_s = 32'd0;
    swp_word_s = 32'd0;
    if (rd_valid_s) begin
      upd_word_s = make_update_word(rd_data_s, ~front_sel_r);
    end else begin
      upd_word_s = 32'd0;
    end
    if (state_r == FLUSH) begin
      swp_word_s = swap_vld_r[0] ? make_swap_word(swap_id_r[0], ~front_sel_r) : 32'd0;
    end else begin
      swp_word_s = swap_vld_r[nxt_idx_s] ? make_swap_word(swap_id_r[nxt_idx_s], ~front_sel_r) : 32'd0;
    end
  end

  // Vblank edge detector: one trigger per frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vb_r   <= 1'b0;
      vb_d_r <= 1'b0;
    end else begin
      vb_r   <= (vcount == V_ACTIVE);
      vb_d_r <= vb_r;
    end
  end

  assign trigger_s = vb_r & ~vb_d_r;

  // Scheduler FSM with registered bus word, busy and done outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      idx_r       <= {SLOT_AW{1'b0}};
      disp_r      <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      front_sel_r <= 1'b0;
      swap_vld_r  <= {N_SLOTS{1'b0}};
      for (int i = 0; i < N_SLOTS; i++) begin
        swap_id_r[i] <= 6'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          disp_r <= 32'd0;
          if (trigger_s) begin
            state_r       <= FLUSH;
            idx_r         <= {SLOT_AW{1'b0}};
            busy_r        <= 1'b1;
            disp_r        <= upd_word_s;
            swap_id_r[0]  <= rd_data_s[COMP_MSB:COMP_LSB];
            swap_vld_r[0] <= rd_valid_s;
          end
        end
        FLUSH: begin
          if (idx_r == LAST_IDX) begin
            state_r <= SWAP;
            idx_r   <= {SLOT_AW{1'b0}};
            disp_r  <= swp_word_s;
          end else begin
            idx_r                 <= nxt_idx_s;
            disp_r                <= upd_word_s;
            swap_id_r[nxt_idx_s]  <= rd_data_s[COMP_MSB:COMP_LSB];
            swap_vld_r[nxt_idx_s] <= rd_valid_s;
          end
        end
        SWAP: begin
          if (idx_r == LAST_IDX) begin
            state_r <= DONE;
            idx_r   <= {SLOT_AW{1'b0}};
            disp_r  <= 32'd0;
            done_r  <= 1'b1;
          end else begin
            idx_r  <= nxt_idx_s;
            disp_r <= swp_word_s;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          idx_r       <= {SLOT_AW{1'b0}};
          disp_r      <= 32'd0;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          front_sel_r <= ~front_sel_r;
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= {SLOT_AW{1'b0}};
          disp_r  <= 32'd0;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign disp_writedata = disp_r;
  assign sched_busy     = busy_r;
  assign frame_done     = done_r;

`ifdef SPRITE_SCHED_STATUS_EN
  logic        overrun_r;
  logic [15:0] frame_cnt_r;

  // Sticky overrun on a trigger while busy; frame counter counts DONE states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_r   <= 1'b0;
      frame_cnt_r <= 16'd0;
    end else begin
      if (trigger_s && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end else if (host_write && (host_address == {SLOT_AW{1'b0}}) && (host_writedata == 32'd0)) begin
        overrun_r <= 1'b0;
      end
      if (state_r == DONE) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
    end
  end

  assign status_readdata = {busy_r, overrun_r, front_sel_r, 13'd0, frame_cnt_r};
`else
  assign status_readdata = 32'd0;
`endif

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Self-checking bench for sprite_frame_scheduler: table-driven frames plus
// hand-written corner-case sequences, checked through an expected-word queue.
module tb_sprite_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        host_write = 1'b0;
  logic [2:0]  host_address = 3'd0;
  logic [31:0] host_writedata = 32'd0;
  logic [9:0]  hcount = 10'd0;
  logic [9:0]  vcount = 10'd0;
  logic [31:0] disp_writedata;
  logic        sched_busy;
  logic        frame_done;
  logic [31:0] status_readdata;

  sprite_frame_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .host_write      (host_write),
    .host_address    (host_address),
    .host_writedata  (host_writedata),
    .hcount          (hcount),
    .vcount          (vcount),
    .disp_writedata  (disp_writedata),
    .sched_busy      (sched_busy),
    .frame_done      (frame_done),
    .status_readdata (status_readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] upd0;  // update word when front_sel=0
    logic [31:0] upd1;  // update word when front_sel=1
    logic [31:0] swp0;
    logic [31:0] swp1;
  } vec_t;

  typedef struct packed {
    logic [31:0] word;
    logic        done;
  } exp_t;

  vec_t        vecs [4];
  exp_t        exp_q [$];
  logic [31:0] slot_m [8];
  logic        front_m;
  logic        ovr_m;
  int          cnt_m;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          run_len = 0;
  exp_t        got_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push_frame(input logic [31:0] upd [8], input logic [31:0] swp [8]);
    exp_t e;
    for (int i = 0; i < 8; i++) begin e.word = upd[i]; e.done = 1'b0; exp_q.push_back(e); end
    for (int i = 0; i < 8; i++) begin e.word = swp[i]; e.done = 1'b0; exp_q.push_back(e); end
    e.word = 32'd0; e.done = 1'b1; exp_q.push_back(e);
  endtask

  task automatic push_table(input logic front);
    logic [31:0] upd [8];
    logic [31:0] swp [8];
    for (int i = 0; i < 8; i++) begin upd[i] = 32'd0; swp[i] = 32'd0; end
    for (int k = 0; k < 4; k++) begin
      upd[vecs[k].addr] = front ? vecs[k].upd1 : vecs[k].upd0;
      swp[vecs[k].addr] = front ? vecs[k].swp1 : vecs[k].swp0;
    end
    push_frame(upd, swp);
  endtask

  task automatic push_model(input logic front);
    logic [31:0] upd [8];
    logic [31:0] swp [8];
    logic [5:0]  c;
    for (int i = 0; i < 8; i++) begin
      c = slot_m[i][31:26];
      upd[i] = (c == 6'd0) ? 32'd0 : {slot_m[i][31:14], ~front, slot_m[i][12:0]};
      swp[i] = (c == 6'd0) ? 32'd0 : {c, 5'd0, 4'hF, 3'd0, ~front, 13'd0};
    end
    push_frame(upd, swp);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [31:0] d);
    host_write = 1'b1; host_address = a; host_writedata = d;
    edges(1);
    host_write = 1'b0; host_writedata = 32'd0;
    slot_m[a] = d;
  endtask

  // Raise vcount to the vblank line for one cycle; returns just after edge E1.
  task automatic kick();
    edges(1);
    vcount = 10'd480;
    edges(1);
    vcount = 10'd0;
  endtask

  task automatic wait_frame(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || sched_busy) && n < 60) begin edges(1); n++; end
    chk({nm, " completion"}, (n < 60) ? 32'd1 : 32'd0, 32'd1);
    front_m = ~front_m;
    cnt_m++;
  endtask

  task automatic chk_status(input string nm);
`ifdef SPRITE_SCHED_STATUS_EN
    chk(nm, status_readdata, {1'b0, ovr_m, front_m, 13'd0, 16'(cnt_m)});
`else
    chk(nm, status_readdata, 32'd0);
`endif
  endtask

  // Monitor: every busy cycle pops one expected record; check run length at the end.
  always @(negedge clk) begin
    if (!reset) begin
      run_len = 0;
    end else if (sched_busy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected busy cycle", 32'd1, 32'd0);
      end else begin
        got_e = exp_q.pop_front();
        chk($sformatf("bus word %0d", run_len), disp_writedata, got_e.word);
        chk($sformatf("frame_done %0d", run_len), {31'd0, frame_done}, {31'd0, got_e.done});
      end
      run_len++;
    end else begin
      if (run_len != 0) begin
        chk("sequence length", run_len, 32'd17);
        chk("idle bus", disp_writedata, 32'd0);
        chk("idle frame_done", {31'd0, frame_done}, 32'd0);
      end
      run_len = 0;
    end
  end

  initial begin
    vecs[0] = '{3'd2, 32'h25AB_CDEF, 32'h25AB_EDEF, 32'h25AB_CDEF, 32'h241E_2000, 32'h241E_0000};
    vecs[1] = '{3'd0, 32'h0C00_2001, 32'h0C00_2001, 32'h0C00_0001, 32'h0C1E_2000, 32'h0C1E_0000};
    vecs[2] = '{3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_DFFF, 32'hFC1E_2000, 32'hFC1E_0000};
    vecs[3] = '{3'd7, 32'h03FF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    for (int i = 0; i < 8; i++) slot_m[i] = 32'd0;
    front_m = 1'b0; ovr_m = 1'b0; cnt_m = 0;

    // Reset state
    #12;
    chk("reset bus", disp_writedata, 32'd0);
    chk("reset busy", {31'd0, sched_busy}, 32'd0);
    chk("reset frame_done", {31'd0, frame_done}, 32'd0);
    chk("reset status", status_readdata, 32'd0);
    edges(1);
    reset = 1'b1;
    edges(1);

    // Frames 1 and 2 from the table: back buffer alternates
    for (int k = 0; k < 4; k++) host_wr(vecs[k].addr, vecs[k].wdata);
    push_table(front_m);
    kick();
    wait_frame("frame1");
    chk_status("status frame1");
    push_table(front_m);
    kick();
    wait_frame("frame2");
    chk_status("status frame2");

    // Frame 3: write slot2 in the very cycle it is read for flush
    push_model(front_m);
    kick();
    edges(2);
    host_write = 1'b1; host_address = 3'd2; host_writedata = 32'h2412_3456;
    edges(1);
    host_write = 1'b0; host_writedata = 32'd0;
    slot_m[2] = 32'h2412_3456;
    wait_frame("frame3");

    // Frame 4: new payload visible; change slot2 comp_id during SWAP
    push_model(front_m);
    kick();
    edges(10);
    chk("busy in swap", {31'd0, sched_busy}, 32'd1);
    host_wr(3'd2, 32'h4400_0123);
    wait_frame("frame4");

    // Frame 5: new comp_id used; second trigger mid-sequence is ignored
    push_model(front_m);
    kick();
    edges(5);
    vcount = 10'd480;
    edges(1);
    vcount = 10'd0;
    wait_frame("frame5");
`ifdef SPRITE_SCHED_STATUS_EN
    ovr_m = 1'b1;
`endif
    chk_status("status overrun");
    host_wr(3'd0, 32'd0);
    ovr_m = 1'b0;
    edges(1);
    chk_status("status overrun cleared");

    // Frame 6: reset during SWAP aborts at once
    push_model(front_m);
    kick();
    edges(11);
    reset = 1'b0;
    #1;
    chk("abort bus", disp_writedata, 32'd0);
    chk("abort busy", {31'd0, sched_busy}, 32'd0);
    chk("abort status", status_readdata, 32'd0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) slot_m[i] = 32'd0;
    front_m = 1'b0; ovr_m = 1'b0; cnt_m = 0;
    edges(2);
    reset = 1'b1;
    edges(1);

    // Frame 7: all slots invalid, every word zero
    push_model(front_m);
    kick();
    wait_frame("frame7");
    chk_status("status after reset frame");

    edges(3);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
